alu_scheduler: RTL and testbench
================================

# alu_scheduler

Round-robin scheduler that shares one `Hierarchical_ALU` instance between `NUM_REQ` requesters. It grants one request at a time and latches that request's opcode and operands. It then drives the ALU through the clear / start / wait-for-done sequence the ALU control modules require, and returns the result to the granted requester with a one-cycle valid pulse. A watchdog bounds the wait so that a missing `done` cannot hang the shared resource.

## Interface
- `WIDTH`, 4, operand, opcode and result width; matches the ALU `WIDTH`.
- `NUM_REQ`, 4, number of requesters; minimum 2.
- `TIMEOUT`, 64, maximum cycles spent in WAIT before the operation is aborted.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level.
- `req_opcode`  in  NUM_REQ*WIDTH  flattened opcodes; requester i occupies slice [i*WIDTH +: WIDTH].
- `req_in1`, `req_in2`  in  NUM_REQ*WIDTH  flattened operands, same slicing as `req_opcode`.
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse marking operand capture.
- `resp_valid`  out  NUM_REQ  one-hot, one-cycle pulse to the granted requester.
- `resp_high`, `resp_low`  out  WIDTH  result, broadcast to all requesters; valid only while `resp_valid` is high.
- `resp_flag`  out  1  ALU flag, captured together with the result.
- `resp_error`  out  1  timeout indication, qualified by `resp_valid`.
- `alu_clear`  out  1  drives the ALU's active-high `reset`.
- `alu_start`  out  1  drives the ALU `start`.
- `alu_opcode`, `alu_in1`, `alu_in2`  out  WIDTH  latched command to the ALU.
- `alu_high`, `alu_low`  in  WIDTH  ALU `out_high` / `out_low`.
- `alu_flag`, `alu_done`  in  1  ALU `flag` / `done`.

## Operation
- **FSM states:** IDLE, CLEAR, SETTLE, START, WAIT, RESP. All outputs are registered.
- **IDLE:** if `req` is nonzero, the round-robin pick selects the first set bit searching upward from `last+1` (mod NUM_REQ).
  - Capture the selected requester's opcode and operands into `alu_*`.
  - Assert `grant[i]`, set `last=i`, go to CLEAR.
- **CLEAR:** `alu_clear=1` for one cycle.
- **SETTLE:** one idle cycle with clear and start both low.
- **START:** `alu_start=1` for one cycle.
- **WAIT:** increment the watchdog counter each cycle.
  - On `alu_done`: capture `alu_high`, `alu_low` and `alu_flag`, clear `resp_error`, go to RESP.
  - On count reaching TIMEOUT: result registers become 0, set `resp_error`, go to RESP.
  - If `alu_done` coincides with timeout, `alu_done` wins.
- **RESP:** `resp_valid[last]=1` for one cycle, then return to IDLE.
- **Request handshake:** `req` is sampled only in IDLE. A requester holds `req` and its operands stable until it sees `grant`, then drops `req` within 3 cycles. A `req` still high on return to IDLE is treated as a new request.
- **Ignored inputs:** `alu_done` is ignored outside WAIT. `alu_opcode` is passed through untouched; the scheduler does not decode it.
- **Reset (`reset` low, any state):** go to IDLE immediately.
  - All outputs drop to 0.
  - `last` resets to NUM_REQ-1, so requester 0 has first priority.
  - An in-flight operation is discarded with no `resp_valid`.
  - The watchdog counter clears.

## Timing
- Edge E0, in IDLE with `req` set: `grant` is high during cycle E0..E1.
- `alu_clear` is high during E1..E2, `alu_start` during E3..E4.
- If `alu_done` is sampled at edge E3+D (D ≥ 1), `resp_valid` is high during E3+D..E4+D.
  - The next grant comes no earlier than edge E4+D.
  - Throughput is one operation per D+5 cycles.
- **Timeout case:** `resp_valid` rises TIMEOUT+4 cycles after the grant edge.
- **Fairness:** with all requesters continuously requesting, grant order is 0,1,…,NUM_REQ-1,0,… No requester waits more than NUM_REQ-1 operations.

## Structure
- Package `alu_sched_pkg`: state encoding constants, and the default `TIMEOUT` width derived as $clog2(TIMEOUT+1).
- Sub-module `rr_pick`: combinational round-robin priority selector.
  - Inputs: `req` and `last`.
  - Outputs: one-hot pick and its index.
  - Instantiated once.

## Test plan
- **Single request:** req=0001, opcode=0, in1=3, in2=5, behavioural ALU returns done 3 cycles after start with high=0, low=8, flag=0.
  - Expect `grant[0]` at E0 and `alu_start` at E3.
  - Expect `resp_valid=0001` with low=8, high=0, `resp_error=0`.
- **Simultaneous requests:** req=0110 asserted together.
  - Expect grant order 1 then 2.
  - Each `resp_valid` pulse carries that requester's result; no overlap between the two operations.
- **Full contention:** req=1111 held with re-request after each response, for 8 operations.
  - Expect grant sequence 0,1,2,3,0,1,2,3 and no starvation.
- **Timeout:** `alu_done` tied low.
  - Expect `resp_valid` TIMEOUT+4 cycles after grant, with `resp_error=1` and a zero result.
- **Done coincides with timeout:** `alu_done` arrives exactly on the TIMEOUT cycle.
  - Expect the result captured and `resp_error=0`.
- **Reset mid-operation:** `reset` pulled low during WAIT.
  - Expect all outputs 0 asynchronously and no `resp_valid`.
  - Expect the next request to be granted to requester 0 first.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: FSM state encoding and watchdog counter sizing.
package alu_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETTLE = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    localparam int DEF_TIMEOUT = 64;

    // Watchdog counter must be able to hold the value TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Signal bundle between the scheduler, its requesters and the shared ALU.
// master is the scheduler view; slave is the requester/ALU view.
interface alu_scheduler_if #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_opcode;
    logic [NUM_REQ*WIDTH-1:0] req_in1;
    logic [NUM_REQ*WIDTH-1:0] req_in2;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_high;
    logic [WIDTH-1:0]         resp_low;
    logic                     resp_flag;
    logic                     resp_error;
    logic                     alu_clear;
    logic                     alu_start;
    logic [WIDTH-1:0]         alu_opcode;
    logic [WIDTH-1:0]         alu_in1;
    logic [WIDTH-1:0]         alu_in2;
    logic [WIDTH-1:0]         alu_high;
    logic [WIDTH-1:0]         alu_low;
    logic                     alu_flag;
    logic                     alu_done;

    modport master (
        input  req, req_opcode, req_in1, req_in2,
        input  alu_high, alu_low, alu_flag, alu_done,
        output grant, resp_valid, resp_high, resp_low, resp_flag, resp_error,
        output alu_clear, alu_start, alu_opcode, alu_in1, alu_in2
    );

    modport slave (
        output req, req_opcode, req_in1, req_in2,
        output alu_high, alu_low, alu_flag, alu_done,
        input  grant, resp_valid, resp_high, resp_low, resp_flag, resp_error,
        input  alu_clear, alu_start, alu_opcode, alu_in1, alu_in2
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching upward from last+1.
// Zero latency; o_vld low when no request is pending.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_vld
);
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_pick = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (!o_vld && i_req[w_cand]) begin
                o_vld          = 1'b1;
                o_idx          = w_cand;
                o_pick[w_cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU among NUM_REQ requesters: grant, clear, settle, start, wait for done, respond.
// One operation per D+5 cycles; a watchdog aborts WAIT after TIMEOUT cycles with resp_error.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    alu_scheduler_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_resp_vld, w_resp_vld_nxt;
    logic               r_clear, w_clear_nxt;
    logic               r_start, w_start_nxt;
    logic [WIDTH-1:0]   r_opc, w_opc_nxt;
    logic [WIDTH-1:0]   r_in1, w_in1_nxt;
    logic [WIDTH-1:0]   r_in2, w_in2_nxt;
    logic [WIDTH-1:0]   r_high, w_high_nxt;
    logic [WIDTH-1:0]   r_low, w_low_nxt;
    logic               r_flag, w_flag_nxt;
    logic               r_err, w_err_nxt;

    logic [NUM_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_vld;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .i_req  (bus.req),
        .i_last (r_last),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_vld  (w_pick_vld)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_grant_nxt    = '0;
        w_resp_vld_nxt = '0;
        w_clear_nxt    = 1'b0;
        w_start_nxt    = 1'b0;
        w_opc_nxt      = r_opc;
        w_in1_nxt      = r_in1;
        w_in2_nxt      = r_in2;
        w_high_nxt     = r_high;
        w_low_nxt      = r_low;
        w_flag_nxt     = r_flag;
        w_err_nxt      = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_grant_nxt = w_pick;
                    w_last_nxt  = w_pick_idx;
                    w_opc_nxt   = bus.req_opcode[w_pick_idx*WIDTH +: WIDTH];
                    w_in1_nxt   = bus.req_in1[w_pick_idx*WIDTH +: WIDTH];
                    w_in2_nxt   = bus.req_in2[w_pick_idx*WIDTH +: WIDTH];
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_clear_nxt = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: w_state_nxt = S_START;
            S_START: begin
                w_start_nxt = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // done is checked first so a completion on the timeout cycle is kept
                if (bus.alu_done) begin
                    w_high_nxt     = bus.alu_high;
                    w_low_nxt      = bus.alu_low;
                    w_flag_nxt     = bus.alu_flag;
                    w_err_nxt      = 1'b0;
                    w_resp_vld_nxt = NUM_REQ'(1) << r_last;
                    w_state_nxt    = S_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_high_nxt     = '0;
                    w_low_nxt      = '0;
                    w_flag_nxt     = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_resp_vld_nxt = NUM_REQ'(1) << r_last;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_cnt      <= '0;
            r_grant    <= '0;
            r_resp_vld <= '0;
            r_clear    <= 1'b0;
            r_start    <= 1'b0;
            r_opc      <= '0;
            r_in1      <= '0;
            r_in2      <= '0;
            r_high     <= '0;
            r_low      <= '0;
            r_flag     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_resp_vld <= w_resp_vld_nxt;
            r_clear    <= w_clear_nxt;
            r_start    <= w_start_nxt;
            r_opc      <= w_opc_nxt;
            r_in1      <= w_in1_nxt;
            r_in2      <= w_in2_nxt;
            r_high     <= w_high_nxt;
            r_low      <= w_low_nxt;
            r_flag     <= w_flag_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.grant      = r_grant;
    assign bus.resp_valid = r_resp_vld;
    assign bus.resp_high  = r_high;
    assign bus.resp_low   = r_low;
    assign bus.resp_flag  = r_flag;
    assign bus.resp_error = r_err;
    assign bus.alu_clear  = r_clear;
    assign bus.alu_start  = r_start;
    assign bus.alu_opcode = r_opc;
    assign bus.alu_in1    = r_in1;
    assign bus.alu_in2    = r_in2;
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: a schedule-level model predicts every output cycle by cycle,
// and per-scenario literal expectations pin latencies, grant order and results.
module tb_alu_scheduler;
    import alu_sched_pkg::*;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int TO = DEF_TIMEOUT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_scheduler_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

    alu_scheduler #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int alu_lat = 3;        // ALU latency D in cycles after start edge; 0 = never done
    bit auto_drop = 1'b1;

    // schedule model: one operation in flight, described by its grant/response cycles
    int m_last = N - 1;
    int m_idx  = 0;
    int m_g    = -1000;
    int m_r    = -1000;
    int m_free = 0;
    logic [W-1:0] m_op, m_a, m_b, m_high, m_low;
    logic         m_flag, m_err;

    int g_log[$], g_cyc[$], s_cyc[$], r_log[$], r_cyc[$], r_low[$], r_high[$], r_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // behavioural ALU: 0 add, 1 multiply, else {xor, and}; flag marks a zero result
    function automatic logic [2*W:0] alu_f(input logic [W-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] r;
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        case (op)
            4'd0:    r = ea + eb;
            4'd1:    r = ea * eb;
            default: r = {a ^ b, a & b};
        endcase
        return {(r == '0), r};
    endfunction

    task automatic set_slot(input int i, input logic [W-1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        bus.req_opcode[i*W +: W] = op;
        bus.req_in1[i*W +: W]    = a;
        bus.req_in2[i*W +: W]    = b;
    endtask

    task automatic clear_logs();
        g_log.delete(); g_cyc.delete(); s_cyc.delete(); r_log.delete();
        r_cyc.delete(); r_low.delete(); r_high.delete(); r_err.delete();
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k;
        k = 0;
        while (r_log.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("resp_count", r_log.size(), n);
    endtask

    task automatic wait_grant(input int n, input int budget);
        int k;
        k = 0;
        while (g_log.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("grant_count", g_log.size(), n);
    endtask

    // model: advances on every edge from the request levels the bench is driving
    initial begin
        logic [2*W:0] res;
        int d, j;
        bit found;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                m_last = N - 1; m_g = -1000; m_r = -1000; m_free = 0;
            end else if (cyc >= m_free && bus.req != '0) begin
                found = 1'b0;
                j = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && bus.req[(m_last + k) % N]) begin
                        found = 1'b1;
                        j = (m_last + k) % N;
                    end
                end
                m_idx = j; m_last = j; m_g = cyc;
                m_op = bus.req_opcode[j*W +: W];
                m_a  = bus.req_in1[j*W +: W];
                m_b  = bus.req_in2[j*W +: W];
                if (alu_lat != 0 && alu_lat <= TO + 1) begin
                    d = alu_lat;
                    res = alu_f(m_op, m_a, m_b);
                    {m_flag, m_high, m_low} = res;
                    m_err = 1'b0;
                end else begin
                    d = TO + 1;
                    {m_flag, m_high, m_low} = '0;
                    m_err = 1'b1;
                end
                m_r    = cyc + 3 + d;
                m_free = m_r + 2;
            end
        end
    end

    // compare process: every cycle, DUT outputs against the model; also logs events
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_grant", bus.grant, '0);
                chk("rst_resp_valid", bus.resp_valid, '0);
                chk("rst_alu_clear", bus.alu_clear, '0);
                chk("rst_alu_start", bus.alu_start, '0);
                chk("rst_alu_cmd", {bus.alu_opcode, bus.alu_in1, bus.alu_in2}, '0);
                chk("rst_resp_data", {bus.resp_high, bus.resp_low, bus.resp_flag, bus.resp_error}, '0);
            end else begin
                chk("grant", bus.grant, (cyc == m_g) ? oh(m_idx) : '0);
                chk("alu_clear", bus.alu_clear, cyc == m_g + 1);
                chk("alu_start", bus.alu_start, cyc == m_g + 3);
                chk("resp_valid", bus.resp_valid, (cyc == m_r) ? oh(m_idx) : '0);
                if (cyc == m_r) begin
                    chk("resp_high", bus.resp_high, m_high);
                    chk("resp_low", bus.resp_low, m_low);
                    chk("resp_flag", bus.resp_flag, m_flag);
                    chk("resp_error", bus.resp_error, m_err);
                end
                if (cyc >= m_g && cyc <= m_r)
                    chk("alu_cmd", {bus.alu_opcode, bus.alu_in1, bus.alu_in2}, {m_op, m_a, m_b});
            end
            if (bus.grant != '0) begin g_log.push_back(idx_of(bus.grant)); g_cyc.push_back(cyc); end
            if (bus.alu_start) s_cyc.push_back(cyc);
            if (bus.resp_valid != '0) begin
                r_log.push_back(idx_of(bus.resp_valid)); r_cyc.push_back(cyc);
                r_low.push_back(int'(bus.resp_low)); r_high.push_back(int'(bus.resp_high));
                r_err.push_back(int'(bus.resp_error));
            end
        end
    end

    // requesters drop req on seeing their grant
    initial begin
        forever begin
            @(posedge clk); #1;
            if (auto_drop) bus.req = bus.req & ~bus.grant;
        end
    end

    // behavioural ALU answering start with a done pulse sampled D edges later
    initial begin
        logic [2*W:0] res;
        bit ok;
        bus.alu_done = 1'b0; bus.alu_high = '0; bus.alu_low = '0; bus.alu_flag = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset && bus.alu_start && alu_lat > 0) begin
                res = alu_f(bus.alu_opcode, bus.alu_in1, bus.alu_in2);
                ok = 1'b1;
                for (int k = 1; k < alu_lat; k++) begin
                    @(posedge clk); #1;
                    if (!reset) ok = 1'b0;
                end
                if (ok) begin
                    {bus.alu_flag, bus.alu_high, bus.alu_low} = res;
                    bus.alu_done = 1'b1;
                    @(posedge clk); #1;
                    bus.alu_done = 1'b0;
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus.req = '0; bus.req_opcode = '0; bus.req_in1 = '0; bus.req_in2 = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // single request: 3 + 5 with D = 3
        repeat (2) @(posedge clk); #2;
        clear_logs(); alu_lat = 3;
        set_slot(0, 4'd0, 4'd3, 4'd5);
        bus.req = 4'b0001;
        wait_resp(1, 100);
        chk("t1_grant_idx", qget(g_log, 0), 0);
        chk("t1_start_ofs", qget(s_cyc, 0) - qget(g_cyc, 0), 3);
        chk("t1_resp_ofs", qget(r_cyc, 0) - qget(g_cyc, 0), 6);
        chk("t1_resp_idx", qget(r_log, 0), 0);
        chk("t1_low", qget(r_low, 0), 8);
        chk("t1_high", qget(r_high, 0), 0);
        chk("t1_err", qget(r_err, 0), 0);

        // simultaneous requests 1 and 2, D = 2
        repeat (3) @(posedge clk); #2;
        clear_logs(); alu_lat = 2;
        set_slot(1, 4'd1, 4'd2, 4'd7);
        set_slot(2, 4'd0, 4'd15, 4'd15);
        bus.req = 4'b0110;
        wait_resp(2, 100);
        chk("t2_grant0", qget(g_log, 0), 1);
        chk("t2_grant1", qget(g_log, 1), 2);
        chk("t2_resp0", qget(r_log, 0), 1);
        chk("t2_resp1", qget(r_log, 1), 2);
        chk("t2_low0", qget(r_low, 0), 14);
        chk("t2_high0", qget(r_high, 0), 0);
        chk("t2_low1", qget(r_low, 1), 14);
        chk("t2_high1", qget(r_high, 1), 1);
        chk("t2_gap", qget(g_cyc, 1) - qget(g_cyc, 0), 7);
        chk("t2_no_overlap", qget(g_cyc, 1) > qget(r_cyc, 0), 1);

        // timeout: done never arrives
        repeat (3) @(posedge clk); #2;
        clear_logs(); alu_lat = 0;
        set_slot(3, 4'd2, 4'd6, 4'd3);
        bus.req = 4'b1000;
        wait_resp(1, 150);
        chk("t3_grant_idx", qget(g_log, 0), 3);
        chk("t3_resp_ofs", qget(r_cyc, 0) - qget(g_cyc, 0), 68);
        chk("t3_err", qget(r_err, 0), 1);
        chk("t3_low", qget(r_low, 0), 0);
        chk("t3_high", qget(r_high, 0), 0);

        // done lands on the timeout cycle
        repeat (3) @(posedge clk); #2;
        clear_logs(); alu_lat = TO + 1;
        set_slot(0, 4'd0, 4'd9, 4'd9);
        bus.req = 4'b0001;
        wait_resp(1, 150);
        chk("t4_resp_ofs", qget(r_cyc, 0) - qget(g_cyc, 0), 68);
        chk("t4_err", qget(r_err, 0), 0);
        chk("t4_low", qget(r_low, 0), 2);
        chk("t4_high", qget(r_high, 0), 1);

        // reset during WAIT
        repeat (3) @(posedge clk); #2;
        clear_logs(); alu_lat = 0;
        set_slot(2, 4'd1, 4'd3, 4'd3);
        bus.req = 4'b0100;
        wait_grant(1, 50);
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t5_async_grant", bus.grant, '0);
        chk("t5_async_resp_valid", bus.resp_valid, '0);
        chk("t5_async_alu_opcode", bus.alu_opcode, '0);
        chk("t5_async_alu_in1", bus.alu_in1, '0);
        chk("t5_async_alu_in2", bus.alu_in2, '0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (TO + 10) @(posedge clk);
        chk("t5_no_resp", r_log.size(), 0);

        // full contention after reset: requester 0 first, then strict rotation
        #2;
        clear_logs(); alu_lat = 1; auto_drop = 1'b0;
        for (int i = 0; i < N; i++) set_slot(i, W'(i % 2), W'(i + 1), W'(i + 6));
        bus.req = 4'b1111;
        wait_resp(8, 120);
        bus.req = '0;
        auto_drop = 1'b1;
        for (int k = 0; k < 8; k++) chk($sformatf("t6_grant%0d", k), qget(g_log, k), k % N);
        chk("t6_gap", qget(g_cyc, 1) - qget(g_cyc, 0), 6);

        repeat (10) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
